// File: rtl/legv8_instr_encoder_if.sv
// Field-input and instruction-memory write bus of the LEGv8 instruction encoder.
// The master drives the fields and imem_ready; the slave (encoder) drives the rest.
interface legv8_instr_encoder_if #(
    parameter int unsigned AW = 6
);
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    kind;
    logic [4:0]    rd;
    logic [4:0]    rn;
    logic [4:0]    rm;
    logic [18:0]   imm;
    logic [1:0]    hw;
    logic          imem_we;
    logic          imem_ready;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   count;
    logic          full;

    modport master (
        output in_valid, kind, rd, rn, rm, imm, hw, imem_ready,
        input  in_ready, imem_we, imem_addr, imem_wdata, count, full
    );

    modport slave (
        input  in_valid, kind, rd, rn, rm, imm, hw, imem_ready,
        output in_ready, imem_we, imem_addr, imem_wdata, count, full
    );
endinterface

// File: rtl/legv8_instr_encoder.sv
// Encodes decoded LEGv8 fields into 32-bit instruction words and writes them to
// consecutive instruction-memory addresses, one word per accept/write pair.
module legv8_instr_encoder #(
    parameter int unsigned AW   = 6,
    parameter int unsigned BASE = 0
) (
    input logic                  clk,
    input logic                  reset,
    input logic                  clear,
    legv8_instr_encoder_if.slave bus
);
    localparam int unsigned   DEPTH    = 1 << AW;
    localparam logic [AW-1:0] BaseAddr = AW'(BASE);
    localparam logic [AW:0]   DepthCnt = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StWrite, StFull} state_e;

    state_e        state_q, state_d;
    logic          we_q, we_d;
    logic          in_ready_q, in_ready_d;
    logic          full_q, full_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   enc;
    logic [AW:0]   count_inc;

    always_comb begin
        enc = 32'h0;
        unique case (bus.kind)
            3'd0: enc = {11'h458, bus.rm, 6'b0, bus.rn, bus.rd};
            3'd1: enc = {11'h658, bus.rm, 6'b0, bus.rn, bus.rd};
            3'd2: enc = {11'h450, bus.rm, 6'b0, bus.rn, bus.rd};
            3'd3: enc = {11'h550, bus.rm, 6'b0, bus.rn, bus.rd};
            3'd4: enc = {11'h7C2, bus.imm[8:0], 2'b00, bus.rn, bus.rd};
            3'd5: enc = {11'h7C0, bus.imm[8:0], 2'b00, bus.rn, bus.rd};
            3'd6: enc = {8'hB4, bus.imm, bus.rd};
            3'd7: enc = {9'b110100101, bus.hw, bus.imm[15:0], bus.rd};
            default: enc = 32'h0;
        endcase
    end

    assign count_inc = count_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        in_ready_d = in_ready_q;
        full_d     = full_q;
        addr_d     = addr_q;
        count_d    = count_q;
        wdata_d    = wdata_q;
        if (clear) begin
            // A pending word is dropped even if the memory accepts it this cycle.
            state_d    = StIdle;
            we_d       = 1'b0;
            in_ready_d = 1'b1;
            full_d     = 1'b0;
            addr_d     = BaseAddr;
            count_d    = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        wdata_d    = enc;
                        we_d       = 1'b1;
                        in_ready_d = 1'b0;
                        state_d    = StWrite;
                    end
                end
                StWrite: begin
                    if (bus.imem_ready) begin
                        we_d    = 1'b0;
                        addr_d  = addr_q + 1'b1;
                        count_d = count_inc;
                        if (count_inc == DepthCnt) begin
                            state_d = StFull;
                            full_d  = 1'b1;
                        end else begin
                            state_d    = StIdle;
                            in_ready_d = 1'b1;
                        end
                    end
                end
                StFull: begin
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            we_q       <= 1'b0;
            in_ready_q <= 1'b1;
            full_q     <= 1'b0;
            addr_q     <= BaseAddr;
            count_q    <= '0;
            wdata_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            in_ready_q <= in_ready_d;
            full_q     <= full_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            wdata_q    <= wdata_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.count      = count_q;
    assign bus.full       = full_q;
endmodule

// File: tb/tb_legv8_instr_encoder.sv
// Scoreboard bench: stimulus pushes expected {addr, wdata} per committed write,
// monitors pop and compare on every accepted memory write.
module tb_legv8_instr_encoder;
    logic clk = 1'b0;
    logic reset, clear, s_reset, s_clear;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    legv8_instr_encoder_if #(.AW(6)) bus ();
    legv8_instr_encoder_if #(.AW(2)) sbus ();

    legv8_instr_encoder #(.AW(6), .BASE(0)) dut (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .bus   (bus)
    );

    // Small instance starts at 2 so its four writes wrap around address 0.
    legv8_instr_encoder #(.AW(2), .BASE(2)) dut_s (
        .clk   (clk),
        .reset (s_reset),
        .clear (s_clear),
        .bus   (sbus)
    );

    logic [5:0]  exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [1:0]  sexp_addr_q[$];
    logic [31:0] sexp_data_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.imem_we && bus.imem_ready && !reset && !clear) begin
            if (exp_data_q.size() == 0) begin
                chk("unexpected_write", {26'h0, bus.imem_addr}, 32'hFFFF_FFFF);
            end else begin
                chk("write_addr", {26'h0, bus.imem_addr}, {26'h0, exp_addr_q.pop_front()});
                chk("write_data", bus.imem_wdata, exp_data_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (sbus.imem_we && sbus.imem_ready && !s_reset && !s_clear) begin
            if (sexp_data_q.size() == 0) begin
                chk("s_unexpected_write", {30'h0, sbus.imem_addr}, 32'hFFFF_FFFF);
            end else begin
                chk("s_write_addr", {30'h0, sbus.imem_addr}, {30'h0, sexp_addr_q.pop_front()});
                chk("s_write_data", sbus.imem_wdata, sexp_data_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one field set for a single cycle; optionally records the expected commit.
    task automatic issue(input logic [2:0] k, input logic [4:0] d, input logic [4:0] n,
                         input logic [4:0] m, input logic [18:0] i, input logic [1:0] h,
                         input bit expect_it, input logic [5:0] a, input logic [31:0] w);
        bus.kind = k; bus.rd = d; bus.rn = n; bus.rm = m; bus.imm = i; bus.hw = h;
        bus.in_valid = 1'b1;
        if (expect_it) begin
            exp_addr_q.push_back(a);
            exp_data_q.push_back(w);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; clear = 1'b0; s_reset = 1'b1; s_clear = 1'b0;
        bus.in_valid = 1'b0; bus.kind = '0; bus.rd = '0; bus.rn = '0; bus.rm = '0;
        bus.imm = '0; bus.hw = '0; bus.imem_ready = 1'b1;
        sbus.in_valid = 1'b0; sbus.kind = '0; sbus.rd = '0; sbus.rn = '0; sbus.rm = '0;
        sbus.imm = '0; sbus.hw = '0; sbus.imem_ready = 1'b1;
        tick(); tick();
        reset = 1'b0; s_reset = 1'b0;

        chk("rst_we", {31'h0, bus.imem_we}, 32'h0);
        chk("rst_wdata", bus.imem_wdata, 32'h0);
        chk("rst_addr", {26'h0, bus.imem_addr}, 32'h0);
        chk("rst_count", {25'h0, bus.count}, 32'h0);
        chk("rst_full", {31'h0, bus.full}, 32'h0);
        chk("rst_in_ready", {31'h0, bus.in_ready}, 32'h1);

        // ADD x1, x2, x3
        issue(3'd0, 5'd1, 5'd2, 5'd3, 19'h0, 2'd0, 1'b1, 6'd0, 32'h8B03_0041);
        chk("add_we", {31'h0, bus.imem_we}, 32'h1);
        chk("add_busy", {31'h0, bus.in_ready}, 32'h0);
        chk("add_wdata", bus.imem_wdata, 32'h8B03_0041);
        tick();
        chk("add_count", {25'h0, bus.count}, 32'h1);
        chk("add_in_ready", {31'h0, bus.in_ready}, 32'h1);
        chk("add_we_drop", {31'h0, bus.imem_we}, 32'h0);

        clear = 1'b1; tick(); clear = 1'b0;
        chk("clr_count", {25'h0, bus.count}, 32'h0);
        issue(3'd4, 5'd5, 5'd6, 5'd0, 19'd8, 2'd0, 1'b1, 6'd0, 32'hF840_80C5);
        tick();
        issue(3'd6, 5'd0, 5'd0, 5'd0, 19'd3, 2'd0, 1'b1, 6'd1, 32'hB400_0060);
        tick();
        chk("ldur_cbz_count", {25'h0, bus.count}, 32'h2);

        // MOVZ held off by imem_ready for three cycles
        clear = 1'b1; tick(); clear = 1'b0;
        bus.imem_ready = 1'b0;
        issue(3'd7, 5'd9, 5'd0, 5'd0, 19'h1234, 2'd1, 1'b1, 6'd0, 32'hD2A2_4689);
        for (int c = 0; c < 4; c++) begin
            if (c == 3) bus.imem_ready = 1'b1;
            chk("movz_hold_we", {31'h0, bus.imem_we}, 32'h1);
            chk("movz_hold_addr", {26'h0, bus.imem_addr}, 32'h0);
            chk("movz_hold_data", bus.imem_wdata, 32'hD2A2_4689);
            chk("movz_hold_count", {25'h0, bus.count}, 32'h0);
            tick();
        end
        chk("movz_count", {25'h0, bus.count}, 32'h1);

        // clear during WRITE with imem_ready high discards the word
        issue(3'd0, 5'd1, 5'd1, 5'd1, 19'h0, 2'd0, 1'b0, 6'd0, 32'h0);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clrw_count", {25'h0, bus.count}, 32'h0);
        chk("clrw_addr", {26'h0, bus.imem_addr}, 32'h0);
        chk("clrw_we", {31'h0, bus.imem_we}, 32'h0);
        chk("clrw_in_ready", {31'h0, bus.in_ready}, 32'h1);

        // reset during WRITE abandons the word
        issue(3'd1, 5'd2, 5'd2, 5'd2, 19'h0, 2'd0, 1'b0, 6'd0, 32'h0);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rstw_count", {25'h0, bus.count}, 32'h0);
        chk("rstw_wdata", bus.imem_wdata, 32'h0);
        chk("rstw_we", {31'h0, bus.imem_we}, 32'h0);
        issue(3'd1, 5'd0, 5'd0, 5'd0, 19'h0, 2'd0, 1'b1, 6'd0, 32'hCB00_0000);
        tick();
        chk("sub_count", {25'h0, bus.count}, 32'h1);

        // Remaining kinds, with junk in fields each kind must ignore
        issue(3'd3, 5'd31, 5'd30, 5'd29, 19'h7FFFF, 2'd3, 1'b1, 6'd1, 32'hAA1D_03DF);
        tick();
        issue(3'd2, 5'd4, 5'd5, 5'd6, 19'h7FFFF, 2'd3, 1'b1, 6'd2, 32'h8A06_00A4);
        tick();
        issue(3'd5, 5'd7, 5'd8, 5'd31, 19'h7FFFF, 2'd3, 1'b1, 6'd3, 32'hF81F_F107);
        tick();
        issue(3'd6, 5'd3, 5'd31, 5'd31, 19'h7FFFF, 2'd3, 1'b1, 6'd4, 32'hB4FF_FFE3);
        tick();
        issue(3'd7, 5'd0, 5'd31, 5'd31, 19'h7FFFF, 2'd3, 1'b1, 6'd5, 32'hD2FF_FFE0);
        tick();
        chk("mix_count", {25'h0, bus.count}, 32'h6);

        // Small instance: in_valid held high for many cycles; only four words fit
        sbus.kind = 3'd0; sbus.rd = 5'd1; sbus.rn = 5'd2; sbus.rm = 5'd3;
        for (int k = 0; k < 4; k++) begin
            sexp_addr_q.push_back(2'(k + 2));
            sexp_data_q.push_back(32'h8B03_0041);
        end
        sbus.in_valid = 1'b1;
        for (int c = 0; c < 14; c++) tick();
        chk("s_full", {31'h0, sbus.full}, 32'h1);
        chk("s_in_ready", {31'h0, sbus.in_ready}, 32'h0);
        chk("s_we", {31'h0, sbus.imem_we}, 32'h0);
        chk("s_count", {29'h0, sbus.count}, 32'h4);
        chk("s_addr_wrapped", {30'h0, sbus.imem_addr}, 32'h2);
        sbus.in_valid = 1'b0;
        s_clear = 1'b1; tick(); s_clear = 1'b0;
        chk("s_clr_full", {31'h0, sbus.full}, 32'h0);
        chk("s_clr_count", {29'h0, sbus.count}, 32'h0);
        chk("s_clr_in_ready", {31'h0, sbus.in_ready}, 32'h1);

        tick();
        chk("main_queue_drained", exp_data_q.size(), 32'h0);
        chk("small_queue_drained", sexp_data_q.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
